ring_resp: RTL

Responder end of the ring protocol: consumes sequenced request tokens from the ring, checks them against the expected sequence number, and returns one acknowledgement per accepted token. Tracks protocol progress toward K in-order deliveries and exposes `objective`/`error` observation outputs for the RL tester harness. Sits opposite the requester on the same ring link; loss and timeout faults are injected or observed here.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_seq_chk.sv | 45 ++++
 rtl/ring_resp.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// ring_pkg: shared types and helpers for the ring responder.
//   - state_t   : responder FSM states (INIT, IDLE, ACK)
//   - SEQ_W_DEF : default sequence-number width
//   - seq_t     : sequence number at the default width
//   - CNT_W     : width of the progress and idle counters
//   - sat_inc   : saturating increment for CNT_W-bit counters
package ring_pkg;

    localparam int SEQ_W_DEF = 6;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef logic [SEQ_W_DEF-1:0] seq_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ring_seq_chk.sv
// ring_seq_chk: holds the expected sequence number and classifies the
// incoming token against it.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset (expected number returns to 0)
//   advance  - accepted in-order token; expected number steps by one
//   seq      - sequence number of the token being offered
//   exp_seq  - current expected sequence number
//   match    - seq equals exp_seq
//   dup      - seq equals exp_seq-1 (re-send of the last accepted token)
//   mismatch - neither match nor dup
module ring_seq_chk
    import ring_pkg::*;
#(
    parameter int SEQ_W = SEQ_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [SEQ_W-1:0] seq,
    output logic [SEQ_W-1:0] exp_seq,
    output logic             match,
    output logic             dup,
    output logic             mismatch
);

    logic [SEQ_W-1:0] exp_reg;
    logic [SEQ_W-1:0] prev_seq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_reg <= '0;
        end else if (advance) begin
            // Wraps naturally at 2^SEQ_W.
            exp_reg <= exp_reg + {{(SEQ_W-1){1'b0}}, 1'b1};
        end
    end

    assign prev_seq = exp_reg - {{(SEQ_W-1){1'b0}}, 1'b1};
    assign exp_seq  = exp_reg;
    assign match    = (seq == exp_reg);
    assign dup      = (seq == prev_seq);
    assign mismatch = !match && !dup;

endmodule

// File: rtl/ring_resp.sv
// ring_resp: responder end of the ring link. Accepts sequenced request
// tokens, acknowledges each accepted one, and tracks in-order progress
// toward K deliveries. objective/error are observation outputs.
// Optional feature macro: RING_RESP_NACK_EN -- when defined, an out-of-order
// token is answered with a retransmit request (ack_nack=1, ack_seq=expected);
// when undefined such a token is silently consumed and progress is lost.
// Ports:
//   clk, reset            - clock; asynchronous active-low reset
//   req_valid/req_seq     - request token in
//   req_ready             - responder idle and able to take a token
//   ack_valid/ack_seq     - acknowledgement out, held until consumed
//   ack_nack              - ack is a retransmit request (0 without feature)
//   ack_ready             - ring consumes the ack
//   loss                  - fault injection: the offered ack is dropped
//   error                 - sticky: duplicate received after objective
//   objective             - progress reached K-1
module ring_resp
    import ring_pkg::*;
#(
    parameter int K       = 16,
    parameter int TIMEOUT = 8,
    parameter int SEQ_W   = SEQ_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [SEQ_W-1:0] req_seq,
    output logic             req_ready,
    output logic             ack_valid,
    output logic [SEQ_W-1:0] ack_seq,
    output logic             ack_nack,
    input  logic             ack_ready,
    input  logic             loss,
    output logic             error,
    output logic             objective
);

    localparam logic [CNT_W-1:0] K_M1  = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] K_M2  = CNT_W'(K - 2);
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [SEQ_W-1:0] ack_seq_reg, ack_seq_next;
    logic             ack_nack_reg, ack_nack_next;
    logic [CNT_W-1:0] prg_reg, prg_next;
    logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic             stable_reg, stable_next;
    logic             err_reg, err_next;

    logic             handshake;
    logic             advance;
    logic [SEQ_W-1:0] exp_seq;
    logic             seq_match, seq_dup, seq_mismatch;

    ring_seq_chk #(
        .SEQ_W (SEQ_W)
    ) u_seq_chk (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .seq      (req_seq),
        .exp_seq  (exp_seq),
        .match    (seq_match),
        .dup      (seq_dup),
        .mismatch (seq_mismatch)
    );

    assign req_ready = (state_reg == IDLE);
    assign handshake = req_ready && req_valid;
    assign advance   = handshake && seq_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= INIT;
            ack_seq_reg  <= '0;
            ack_nack_reg <= 1'b0;
            prg_reg      <= '0;
            idle_cnt_reg <= '0;
            stable_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ack_seq_reg  <= ack_seq_next;
            ack_nack_reg <= ack_nack_next;
            prg_reg      <= prg_next;
            idle_cnt_reg <= idle_cnt_next;
            stable_reg   <= stable_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ack_seq_next  = ack_seq_reg;
        ack_nack_next = ack_nack_reg;
        prg_next      = prg_reg;
        idle_cnt_next = idle_cnt_reg;
        stable_next   = stable_reg;
        err_next      = err_reg;

        unique case (state_reg)
            INIT: begin
                state_next = IDLE;
            end

            IDLE: begin
                if (handshake) begin
                    if (seq_match) begin
                        ack_seq_next  = exp_seq;
                        ack_nack_next = 1'b0;
                        if (prg_reg < K_M1) begin
                            prg_next = prg_reg + 1'b1;
                        end
                        if (prg_reg == K_M2) begin
                            stable_next = 1'b1;
                        end
                        idle_cnt_next = '0;
                        state_next    = ACK;
                    end else if (seq_dup && stable_reg) begin
                        // Re-send after the link was stable: requester lost
                        // track of an ack that was actually delivered.
                        err_next = 1'b1;
                    end else if (seq_mismatch || seq_dup) begin
`ifdef RING_RESP_NACK_EN
                        // Ask for the token we are still waiting on.
                        ack_seq_next  = exp_seq;
                        ack_nack_next = 1'b1;
                        state_next    = ACK;
`else
                        prg_next    = '0;
                        stable_next = 1'b0;
`endif
                    end
                end else begin
                    // Only idle IDLE cycles count toward the timeout.
                    if (idle_cnt_reg == TO_M1) begin
                        prg_next      = '0;
                        stable_next   = 1'b0;
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = sat_inc(idle_cnt_reg);
                    end
                end
            end

            ACK: begin
                if (loss) begin
                    // Dropped ack breaks the in-order chain.
                    prg_next    = '0;
                    stable_next = 1'b0;
                    state_next  = IDLE;
                end else if (ack_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign ack_valid = (state_reg == ACK);
    assign ack_seq   = ack_seq_reg;
    assign ack_nack  = ack_nack_reg;
    assign error     = err_reg;
    assign objective = (prg_reg == K_M1);

endmodule
